xbar_cfg_loader: RTL and testbench
==================================

Name: xbar_cfg_loader

Overview:
- Configuration controller for the LUT-tile crossbar (31 inputs, 40 outputs, 5-bit select per output).
- Accepts a configuration frame as a stream of 32-bit words over a valid/ready port into a shadow register.
- Scans every select field for out-of-range values, then atomically commits the shadow into the active register that drives the crossbar's mux-config bus.
- Sits between the tile configuration chain and the crossbar; the crossbar never sees a partially loaded or illegal configuration.

Parameters:
- N_IN, 31, number of crossbar inputs; a select value >= N_IN is illegal.
- N_OUT, 40, number of crossbar outputs (select fields).
- SEL_W, 5, bits per select field.
- WORD_W, 32, configuration word width.
- Derived, not overridable: CFG_W = N_OUT*SEL_W = 200; N_WORDS = ceil(CFG_W/WORD_W) = 7.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- io_cfg_start, input, 1: begin a new frame; honoured only in IDLE.
- io_cfg_valid, input, 1: config word valid.
- io_cfg_ready, output, 1: loader accepts a word.
- io_cfg_data, input, WORD_W: config word, least-significant word first.
- io_busy, output, 1: high in any state other than IDLE.
- io_done, output, 1: one-cycle pulse at the end of a frame, whether committed or rejected.
- io_err, output, 1: last frame rejected; sticky until the next accepted start or reset.
- io_err_field, output, 6: index of the first illegal field of the last rejected frame.
- io_mux_configs, output, CFG_W: active configuration to the crossbar; field k is bits [5k+4:5k].

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - io_mux_configs = 0, so every output selects input 0.
  - io_done, io_err and io_err_field = 0; shadow register and counters = 0.
  - Reset asserted mid-frame abandons the frame; nothing partial reaches io_mux_configs.
- States: IDLE, LOAD, CHECK, COMMIT.
- IDLE:
  - io_cfg_ready = 0.
  - On io_cfg_start: clear word_cnt, clear io_err and io_err_field, then go to LOAD.
- LOAD:
  - io_cfg_ready = 1.
  - A beat transfers when io_cfg_valid && io_cfg_ready.
  - Word i is written to shadow bits [32i+31:32i], truncated at CFG_W; the upper 24 bits of word 6 are ignored.
  - word_cnt increments per beat.
  - After the beat with word_cnt == N_WORDS-1, go to CHECK the next cycle.
  - Valid low inserts bubbles with no state change; there is no timeout.
  - io_cfg_start is ignored in LOAD.
- CHECK:
  - field_cnt steps 0..N_OUT-1, one field per cycle, for 40 cycles total.
  - On the first field with a value >= N_IN: set err_flag and latch its index into io_err_field. Later bad fields do not overwrite it.
  - After field N_OUT-1: go to COMMIT if no error, otherwise go to IDLE with io_err = 1 and io_done = 1 on the next cycle.
- COMMIT:
  - One cycle: io_mux_configs <= shadow.
  - Return to IDLE; io_done = 1 in the first IDLE cycle, concurrent with the new io_mux_configs.
- Rejected frame: io_mux_configs is unchanged.
- io_done is registered and high for exactly one cycle per completed frame.
- Latency: start-to-done = 1 + 7 beats (minimum, no bubbles) + 40 + 1 = 49 cycles minimum.
- A start in the same cycle as the io_done pulse (IDLE) is accepted and clears io_err.
- io_busy is combinational from state.

Decomposition:
- Package xbar_cfg_pkg:
  - constants N_IN, N_OUT, SEL_W, WORD_W, CFG_W, N_WORDS;
  - state enum (IDLE/LOAD/CHECK/COMMIT);
  - field-index width constant (6).
- Sub-module xbar_cfg_field_chk: combinational. Takes the shadow and field_cnt; returns the selected 5-bit field and an illegal flag (field >= N_IN). The FSM and registers stay in xbar_cfg_loader.

Test Plan:
- Reset then idle 5 cycles -> io_mux_configs = 0, io_ready = 0, io_busy = 0, io_done never high.
- Start, 7 back-to-back words encoding field k = k mod 31 -> io_done at cycle 49 after start; field 39 reads 8; io_err = 0.
- Same frame with valid deasserted for 3 cycles between words 2 and 3 -> io_done 3 cycles later; identical io_mux_configs.
- Frame with field 12 = 31 and field 20 = 31 -> io_err = 1, io_err_field = 12, io_done pulses, io_mux_configs equals the prior committed value.
- Reset asserted after word 4 of a new frame -> io_mux_configs = 0, state IDLE; a following full legal frame commits correctly.
- io_cfg_start pulsed during LOAD and CHECK -> ignored; word count and result unaffected; start on the io_done cycle begins a new frame and clears io_err.

Source files
------------

// File: rtl/xbar_cfg_pkg.sv
// Shared constants and state type for the crossbar configuration loader.
package xbar_cfg_pkg;

  localparam int unsigned N_IN        = 31;
  localparam int unsigned N_OUT       = 40;
  localparam int unsigned SEL_W       = 5;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned CFG_W       = N_OUT * SEL_W;
  localparam int unsigned N_WORDS     = (CFG_W + WORD_W - 1) / WORD_W;
  localparam int unsigned FIELD_IDX_W = 6;
  localparam int unsigned WORD_CNT_W  = 3;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCheck,
    StCommit
  } state_e;

endpackage

// File: rtl/xbar_cfg_field_chk.sv
// Combinational select-field extractor with out-of-range flag.
module xbar_cfg_field_chk
  import xbar_cfg_pkg::*;
(
  input  logic [CFG_W-1:0]       shadow_i,
  input  logic [FIELD_IDX_W-1:0] field_idx_i,
  output logic [SEL_W-1:0]       field_o,
  output logic                   illegal_o
);

  always_comb begin
    field_o   = shadow_i[field_idx_i * SEL_W +: SEL_W];
    illegal_o = (field_o >= SEL_W'(N_IN));
  end

endmodule

// File: rtl/xbar_cfg_loader.sv
// Loads a crossbar config frame into a shadow register, range-checks every
// select field one per cycle, then commits the shadow atomically.
module xbar_cfg_loader
  import xbar_cfg_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   io_cfg_start,
  input  logic                   io_cfg_valid,
  output logic                   io_cfg_ready,
  input  logic [WORD_W-1:0]      io_cfg_data,
  output logic                   io_busy,
  output logic                   io_done,
  output logic                   io_err,
  output logic [FIELD_IDX_W-1:0] io_err_field,
  output logic [CFG_W-1:0]       io_mux_configs
);

  state_e                 state_q, state_d;
  logic [WORD_CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [FIELD_IDX_W-1:0] field_cnt_q, field_cnt_d;
  logic [CFG_W-1:0]       shadow_q, shadow_d;
  logic [CFG_W-1:0]       mux_q, mux_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   err_flag_q, err_flag_d;
  logic [FIELD_IDX_W-1:0] err_field_q, err_field_d;

  logic [SEL_W-1:0]       cur_field;
  logic                   cur_illegal;

  xbar_cfg_field_chk u_field_chk (
    .shadow_i    (shadow_q),
    .field_idx_i (field_cnt_q),
    .field_o     (cur_field),
    .illegal_o   (cur_illegal)
  );

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    field_cnt_d  = field_cnt_q;
    shadow_d     = shadow_q;
    mux_d        = mux_q;
    done_d       = 1'b0;
    err_d        = err_q;
    err_flag_d   = err_flag_q;
    err_field_d  = err_field_q;
    io_cfg_ready = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (io_cfg_start) begin
          word_cnt_d  = '0;
          err_d       = 1'b0;
          err_field_d = '0;
          state_d     = StLoad;
        end
      end
      StLoad: begin
        io_cfg_ready = 1'b1;
        if (io_cfg_valid) begin
          // Bits of the last word beyond CFG_W are dropped.
          for (int b = 0; b < WORD_W; b++) begin
            if (int'(word_cnt_q) * WORD_W + b < CFG_W) begin
              shadow_d[int'(word_cnt_q) * WORD_W + b] = io_cfg_data[b];
            end
          end
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == WORD_CNT_W'(N_WORDS - 1)) begin
            field_cnt_d = '0;
            err_flag_d  = 1'b0;
            state_d     = StCheck;
          end
        end
      end
      StCheck: begin
        if (cur_illegal && !err_flag_q) begin
          err_flag_d  = 1'b1;
          err_field_d = field_cnt_q;
        end
        if (field_cnt_q == FIELD_IDX_W'(N_OUT - 1)) begin
          if (err_flag_q || cur_illegal) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StCommit;
          end
        end else begin
          field_cnt_d = field_cnt_q + 1'b1;
        end
      end
      StCommit: begin
        mux_d   = shadow_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      word_cnt_q  <= '0;
      field_cnt_q <= '0;
      shadow_q    <= '0;
      mux_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_flag_q  <= 1'b0;
      err_field_q <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      field_cnt_q <= field_cnt_d;
      shadow_q    <= shadow_d;
      mux_q       <= mux_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_flag_q  <= err_flag_d;
      err_field_q <= err_field_d;
    end
  end

  assign io_busy        = (state_q != StIdle);
  assign io_done        = done_q;
  assign io_err         = err_q;
  assign io_err_field   = err_field_q;
  assign io_mux_configs = mux_q;

  // cur_field is exposed by the checker for debug visibility only.
  logic unused_field;
  assign unused_field = ^cur_field;

endmodule

// File: tb/tb_xbar_cfg_loader.sv
// Self-checking bench: frame-level model plus directed frames with literal checks.
module tb_xbar_cfg_loader;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         io_cfg_start = 1'b0;
  logic         io_cfg_valid = 1'b0;
  logic         io_cfg_ready;
  logic [31:0]  io_cfg_data = '0;
  logic         io_busy;
  logic         io_done;
  logic         io_err;
  logic [5:0]   io_err_field;
  logic [199:0] io_mux_configs;

  always #5 clk = ~clk;

  xbar_cfg_loader dut (
    .clk            (clk),
    .reset          (reset),
    .io_cfg_start   (io_cfg_start),
    .io_cfg_valid   (io_cfg_valid),
    .io_cfg_ready   (io_cfg_ready),
    .io_cfg_data    (io_cfg_data),
    .io_busy        (io_busy),
    .io_done        (io_done),
    .io_err         (io_err),
    .io_err_field   (io_err_field),
    .io_mux_configs (io_mux_configs)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame-level model: phase 0 idle, 1 loading, 2 scanning, 3 committing.
  int           m_phase = 0;
  int           m_words, m_scan, m_bad;
  bit           m_live = 0;
  logic [223:0] m_pad;
  logic [199:0] m_shadow = '0;
  logic [199:0] exp_mux = '0;
  logic         exp_done = 1'b0;
  logic         exp_err = 1'b0;
  logic [5:0]   exp_err_field = '0;
  int           e_cnt = 0;
  int           s_edge = 0;

  always @(posedge clk) begin
    e_cnt++;
    exp_done = 1'b0;
    if (reset) begin
      m_phase = 0; m_shadow = '0; exp_mux = '0; exp_err = 1'b0; exp_err_field = '0;
      m_live = 1;
    end else begin
      case (m_phase)
        0: if (io_cfg_start) begin
          m_phase = 1; m_words = 0; exp_err = 1'b0; exp_err_field = '0; s_edge = e_cnt;
        end
        1: if (io_cfg_valid) begin
          m_pad = {24'h0, m_shadow};
          m_pad[32*m_words +: 32] = io_cfg_data;
          m_shadow = m_pad[199:0];
          m_words++;
          if (m_words == 7) begin
            m_phase = 2; m_scan = 0; m_bad = -1;
            for (int k = 39; k >= 0; k--) if (m_shadow[5*k +: 5] >= 5'd31) m_bad = k;
          end
        end
        2: begin
          m_scan++;
          if (m_scan == 40) begin
            if (m_bad < 0) m_phase = 3;
            else begin
              m_phase = 0; exp_done = 1'b1; exp_err = 1'b1; exp_err_field = 6'(m_bad);
            end
          end
        end
        default: begin
          exp_mux = m_shadow; exp_done = 1'b1; m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check_eq("busy", 200'(io_busy), 200'(m_phase != 0));
      check_eq("ready", 200'(io_cfg_ready), 200'(m_phase == 1));
      check_eq("done", 200'(io_done), 200'(exp_done));
      check_eq("err", 200'(io_err), 200'(exp_err));
      check_eq("mux_configs", io_mux_configs, exp_mux);
      if (m_phase == 0) check_eq("err_field", 200'(io_err_field), 200'(exp_err_field));
    end
  end

  // Stimulus helpers
  int           fld [40];
  logic [31:0]  frame_w [7];
  logic [199:0] frame_cfg;

  task automatic build_frame();
    logic [223:0] pad;
    pad = '0;
    for (int k = 0; k < 40; k++) pad[5*k +: 5] = 5'(fld[k]);
    frame_cfg = pad[199:0];
    pad[223:200] = 24'hABCDEF;  // junk that must be discarded
    for (int i = 0; i < 7; i++) frame_w[i] = pad[32*i +: 32];
  endtask

  task automatic do_start();
    @(negedge clk);
    io_cfg_start = 1'b1;
    @(negedge clk);
    io_cfg_start = 1'b0;
  endtask

  task automatic send_words(input int n, input int gap_at, input int gap_len, input bit poke);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        io_cfg_valid = 1'b0;
        repeat (gap_len) @(negedge clk);
      end
      io_cfg_valid = 1'b1;
      io_cfg_data  = frame_w[i];
      io_cfg_start = poke;
      @(negedge clk);
    end
    io_cfg_valid = 1'b0;
    io_cfg_start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    int n;
    n = 0;
    lat = -1;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (io_done === 1'b1) begin
        lat = e_cnt - s_edge + 1;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL done_timeout: got no done after %0d cycles, required a done pulse", n);
  endtask

  logic [199:0] cfg_a, cfg_b;
  int lat;

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("idle_done_low", 200'(io_done), 200'(0));
    end
    check_eq("rst_mux", io_mux_configs, 200'(0));
    check_eq("rst_ready", 200'(io_cfg_ready), 200'(0));
    check_eq("rst_busy", 200'(io_busy), 200'(0));

    // Legal frame, field k = k mod 31
    for (int k = 0; k < 40; k++) fld[k] = k % 31;
    build_frame();
    cfg_a = frame_cfg;
    do_start();
    send_words(7, -1, 0, 1'b0);
    wait_done(lat);
    check_eq("lat_legal", 200'(lat), 200'(49));
    @(negedge clk);
    check_eq("field39", 200'(io_mux_configs[199:195]), 200'(8));
    check_eq("field30", 200'(io_mux_configs[154:150]), 200'(30));
    check_eq("field31", 200'(io_mux_configs[159:155]), 200'(0));
    check_eq("cfg_a", io_mux_configs, cfg_a);
    check_eq("err_legal", 200'(io_err), 200'(0));

    // Same frame, 3-cycle bubble between words 2 and 3
    do_start();
    send_words(7, 3, 3, 1'b0);
    wait_done(lat);
    check_eq("lat_bubble", 200'(lat), 200'(52));
    check_eq("cfg_bubble", io_mux_configs, cfg_a);

    // Illegal fields 12 and 20
    fld[12] = 31;
    fld[20] = 31;
    build_frame();
    do_start();
    send_words(7, -1, 0, 1'b0);
    wait_done(lat);
    check_eq("lat_reject", 200'(lat), 200'(48));
    check_eq("err_reject", 200'(io_err), 200'(1));
    check_eq("err_field12", 200'(io_err_field), 200'(12));
    check_eq("cfg_kept", io_mux_configs, cfg_a);

    // Reset after word 4 of a new frame, then a fresh legal frame
    for (int k = 0; k < 40; k++) fld[k] = 30 - (k % 31);
    build_frame();
    cfg_b = frame_cfg;
    do_start();
    send_words(4, -1, 0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_mux", io_mux_configs, 200'(0));
    check_eq("midrst_busy", 200'(io_busy), 200'(0));
    check_eq("midrst_err", 200'(io_err), 200'(0));
    do_start();
    send_words(7, -1, 0, 1'b0);
    wait_done(lat);
    check_eq("cfg_b", io_mux_configs, cfg_b);
    check_eq("cfg_b_f0", 200'(io_mux_configs[4:0]), 200'(30));

    // Rejected frame with start poked during LOAD and CHECK
    for (int k = 0; k < 40; k++) fld[k] = k % 31;
    fld[12] = 31;
    fld[20] = 31;
    build_frame();
    do_start();
    send_words(7, -1, 0, 1'b1);
    io_cfg_start = 1'b1;
    repeat (5) @(negedge clk);
    io_cfg_start = 1'b0;
    wait_done(lat);
    check_eq("lat_poke", 200'(lat), 200'(48));
    check_eq("err_poke", 200'(io_err), 200'(1));
    check_eq("err_field_poke", 200'(io_err_field), 200'(12));
    check_eq("cfg_b_kept", io_mux_configs, cfg_b);

    // Start on the done cycle clears err and starts a legal frame
    fld[12] = 12;
    fld[20] = 20;
    build_frame();
    io_cfg_start = 1'b1;
    @(negedge clk);
    io_cfg_start = 1'b0;
    check_eq("err_cleared", 200'(io_err), 200'(0));
    check_eq("busy_on_restart", 200'(io_busy), 200'(1));
    send_words(7, -1, 0, 1'b0);
    wait_done(lat);
    check_eq("lat_restart", 200'(lat), 200'(49));
    check_eq("cfg_restart", io_mux_configs, cfg_a);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
